// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch and data requesters plus the single memory port.
// The arbiter takes the master view; the surrounding pipeline/memory take the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;
    logic              if_ack;
    logic              d_ack;
    logic              if_err;
    logic              d_err;
    logic [DATA_W-1:0] rdata;
    logic              stall_if;
    logic              stall_d;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  m_ack, m_rdata,
        output m_req, m_we, m_addr, m_wdata,
        output if_ack, d_ack, if_err, d_err, rdata,
        output stall_if, stall_d
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output m_ack, m_rdata,
        input  m_req, m_we, m_addr, m_wdata,
        input  if_ack, d_ack, if_err, d_err, rdata,
        input  stall_if, stall_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one access at a time,
// with data priority bounded by a starvation counter and a per-access timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 3
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [2:0]        starve_cnt;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic busy;
    logic timeout;
    logic done;
    logic d_grant;
    logic if_grant;

    assign busy    = (state != IDLE);
    assign timeout = busy && !bus.m_ack && (wait_cnt == 8'(TIMEOUT - 1));
    // Reset in the same cycle suppresses completion: an aborted access is never acked.
    assign done    = busy && !rst && (bus.m_ack || timeout);

    // Data wins unless fetch has already waited through STARVE_MAX data grants.
    assign d_grant  = bus.d_req && ((starve_cnt < 3'(STARVE_MAX)) || !bus.if_req);
    assign if_grant = bus.if_req && !d_grant;

    assign bus.m_req   = req_q;
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;

    assign bus.if_ack   = done && (state == IF_BUSY);
    assign bus.d_ack    = done && (state == D_BUSY);
    assign bus.if_err   = bus.if_ack && !bus.m_ack;
    assign bus.d_err    = bus.d_ack && !bus.m_ack;
    assign bus.rdata    = (done && bus.m_ack) ? bus.m_rdata : '0;
    assign bus.stall_if = bus.if_req && !bus.if_ack;
    assign bus.stall_d  = bus.d_req && !bus.d_ack;

    // Access FSM: grant from IDLE, hold captured request until ack or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    unique case (1'b1)
                        d_grant: begin
                            state      <= D_BUSY;
                            req_q      <= 1'b1;
                            we_q       <= bus.d_we;
                            addr_q     <= bus.d_addr;
                            wdata_q    <= bus.d_wdata;
                            starve_cnt <= bus.if_req ? starve_cnt + 3'd1 : 3'd0;
                        end
                        if_grant: begin
                            state      <= IF_BUSY;
                            req_q      <= 1'b1;
                            we_q       <= 1'b0;
                            addr_q     <= bus.if_addr;
                            wdata_q    <= '0;
                            starve_cnt <= 3'd0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (done) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic,
// all cycles checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int TO = 16;
    localparam int SM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .STARVE_MAX(SM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: the single outstanding transaction, if any.
    bit          busy = 0;
    bit          who_d = 0;
    logic [31:0] cur_addr = 0;
    logic [31:0] cur_wdata = 0;
    bit          cur_we = 0;
    int          waited = 0;
    int          streak = 0;
    bit          done_e = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: compare every output against the model.
    task automatic settle();
        bit ok, to, ia, da;
        logic [7:0] ctl;
        #4;
        ok = busy && !rst && bus.m_ack;
        to = busy && !rst && !bus.m_ack && (waited == TO - 1);
        done_e = ok || to;
        ia = done_e && !who_d;
        da = done_e && who_d;
        ctl = {busy, busy && cur_we, ia, da, ia && to, da && to,
               bus.if_req && !ia, bus.d_req && !da};
        check("ctl", {bus.m_req, bus.m_we, bus.if_ack, bus.d_ack,
                      bus.if_err, bus.d_err, bus.stall_if, bus.stall_d}, ctl);
        check("rdata", bus.rdata, ok ? bus.m_rdata : 32'h0);
        if (busy) begin
            check("m_addr", bus.m_addr, cur_addr);
            check("m_wdata", bus.m_wdata, cur_wdata);
        end
    endtask

    // Clock edge: advance the model with the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            busy = 0;
            streak = 0;
        end else if (busy) begin
            if (done_e) busy = 0;
            else waited++;
        end else if (bus.d_req && (streak < SM || !bus.if_req)) begin
            busy = 1; who_d = 1; waited = 0;
            cur_addr = bus.d_addr; cur_wdata = bus.d_wdata; cur_we = bus.d_we;
            streak = bus.if_req ? ((streak < SM) ? streak + 1 : SM) : 0;
        end else if (bus.if_req) begin
            busy = 1; who_d = 0; waited = 0;
            cur_addr = bus.if_addr; cur_wdata = 0; cur_we = 0;
            streak = 0;
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nack;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.m_ack = 0; bus.m_rdata = 0;
        tick();
        settle();
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_rdata", bus.rdata, 0);
        tick();
        rst = 1'b0;

        // Fetch read, acked on the 4th busy cycle.
        bus.if_req = 1; bus.if_addr = 32'h100;
        step();
        repeat (3) step();
        bus.m_ack = 1; bus.m_rdata = 32'h13;
        settle();
        check("if_ack", bus.if_ack, 1);
        check("if_rdata", bus.rdata, 32'h13);
        check("if_addr", bus.m_addr, 32'h100);
        check("if_stall", bus.stall_if, 0);
        tick();
        bus.if_req = 0; bus.m_ack = 0;
        settle();
        check("if_mreq_low", bus.m_req, 0);
        tick();

        // Simultaneous requests: data first, fetch after one idle cycle.
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
        step();
        bus.m_ack = 1;
        settle();
        check("d_we", bus.m_we, 1);
        check("d_addr", bus.m_addr, 32'h2000);
        check("d_ack", bus.d_ack, 1);
        tick();
        bus.d_req = 0; bus.m_ack = 0;
        settle();
        check("gap_idle", bus.m_req, 0);
        tick();
        settle();
        check("if_after_d", {bus.m_req, bus.m_we}, 2'b10);
        check("if_after_d_addr", bus.m_addr, 32'h300);
        tick();
        bus.m_ack = 1;
        step();
        bus.if_req = 0; bus.m_ack = 0;
        do_reset();

        // Data streams continuously: fetch gets every 4th grant.
        bus.if_req = 1; bus.d_req = 1; bus.d_we = 0; bus.m_ack = 1;
        nack = 0;
        for (int c = 0; c < 16; c++) begin
            bus.m_rdata = $urandom;
            settle();
            if (bus.if_ack || bus.d_ack) begin
                check("starve_seq", bus.if_ack, (nack % 4 == 3));
                nack++;
            end
            tick();
        end
        check("starve_acks", nack, 8);
        bus.if_req = 0; bus.d_req = 0; bus.m_ack = 0;
        do_reset();

        // Data timeout with no ack.
        bus.d_req = 1; bus.d_addr = 32'h40;
        step();
        repeat (TO - 1) step();
        settle();
        check("tmo_ack", {bus.d_ack, bus.d_err}, 2'b11);
        check("tmo_rdata", bus.rdata, 0);
        tick();
        bus.d_req = 0;
        settle();
        check("tmo_idle", bus.m_req, 0);
        tick();

        // Ack lands on the timeout cycle: ack wins.
        bus.d_req = 1;
        step();
        repeat (TO - 1) step();
        bus.m_ack = 1; bus.m_rdata = 32'hCAFE0001;
        settle();
        check("late_ack", {bus.d_ack, bus.d_err}, 2'b10);
        check("late_rdata", bus.rdata, 32'hCAFE0001);
        tick();
        bus.d_req = 0; bus.m_ack = 0;
        step();

        // Reset in the middle of a fetch access, then a stray ack.
        bus.if_req = 1; bus.if_addr = 32'h500;
        step();
        repeat (2) step();
        rst = 1;
        step();
        rst = 0; bus.if_req = 0; bus.m_ack = 1;
        settle();
        check("abort_mreq", bus.m_req, 0);
        check("abort_ack", bus.if_ack, 0);
        check("abort_starve", dut.starve_cnt, 0);
        tick();
        bus.m_ack = 0;
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.if_req  = ($urandom_range(9) < 7);
            bus.d_req   = ($urandom_range(9) < 6);
            bus.if_addr = $urandom;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_we    = $urandom_range(1);
            bus.m_rdata = $urandom;
            bus.m_ack   = (c < 1500) ? ($urandom_range(2) == 0)
                                     : ($urandom_range(19) == 0);
            rst = ($urandom_range(199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, max cycles an access waits for m_ack (range 2..255).
REQ-004 Parameter STARVE_MAX, default 3, consecutive data grants tolerated while fetch waits (range 1..7).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 if_req  in  1  fetch stage requests an instruction read.
REQ-008 if_addr  in  ADDR_W  fetch address.
REQ-009 d_req  in  1  memory stage requests a data access.
REQ-010 d_we  in  1  data access is a write.
REQ-011 d_addr / d_wdata  in  ADDR_W / DATA_W  data address / write data.
REQ-012 m_req / m_we  out  1 / 1  shared memory port request / write.
REQ-013 m_addr / m_wdata  out  ADDR_W / DATA_W  shared port address / write data.
REQ-014 m_ack / m_rdata  in  1 / DATA_W  memory completion pulse / read data.
REQ-015 if_ack, d_ack  out  1  one-cycle completion to each requester.
REQ-016 if_err, d_err  out  1  completion was a timeout (qualified by matching ack).
REQ-017 rdata  out  DATA_W  read data, valid with if_ack or d_ack.
REQ-018 stall_if, stall_d  out  1  requester waiting; drives en_IF/en_IFID hold and full-pipeline hold respectively.

Function
REQ-019 FSM states IDLE, IF_BUSY, D_BUSY; one access outstanding at a time.
REQ-020 In IDLE, d_req=1 and starve_cnt<STARVE_MAX -> D_BUSY; else if_req=1 -> IF_BUSY; else d_req=1 -> D_BUSY; else stay IDLE.
REQ-021 At grant, selected address/wdata/we are captured into registers; m_addr/m_wdata/m_we driven from these registers, stable for the whole access.
REQ-022 m_req=1 exactly while state is IF_BUSY or D_BUSY; m_we=0 in IF_BUSY.
REQ-023 Cycle with m_ack=1 in busy state: matching ack output =1 (combinational), err=0, rdata=m_rdata; next state IDLE.
REQ-024 m_ack in IDLE is ignored; acks never asserted in IDLE.
REQ-025 wait_cnt cleared on grant, increments each busy cycle without m_ack; when wait_cnt==TIMEOUT-1 and m_ack=0: matching ack=1, err=1, rdata=0, next state IDLE.
REQ-026 m_ack and timeout in the same cycle: m_ack wins, err=0.
REQ-027 Minimum access: grant edge + 1 busy cycle; one IDLE cycle always separates accesses.
REQ-028 starve_cnt (3 bits): on D grant with if_req=1, increments (saturating at STARVE_MAX); on IF grant, clears; on D grant with if_req=0, clears.
REQ-029 stall_if = if_req AND NOT if_ack; stall_d = d_req AND NOT d_ack (combinational).
REQ-030 Requester dropping req mid-access does not abort: access completes, ack still pulses.
REQ-031 Requests are level: a requester holding req after its ack is re-arbitrated from IDLE next cycle.
REQ-032 rdata = 0 whenever no ack is asserted.

Reset
REQ-033 rst=1 at an edge: state IDLE, wait_cnt=0, starve_cnt=0, address/data/we registers 0, regardless of access in flight.
REQ-034 Outputs during/after reset: m_req=0, m_we=0, if_ack=d_ack=0, errs=0, rdata=0; stall_* follow REQ-029.
REQ-035 An access aborted by reset is never acked; a late m_ack after reset is ignored (REQ-024).

Verification
REQ-036 if_req=1, if_addr=0x100, m_ack 3 cycles after m_req rises, m_rdata=0x00000013 -> m_addr=0x100, if_ack=1 with rdata=0x13, stall_if=0 that cycle, m_req low next cycle.
REQ-037 if_req and d_req (d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF) rise together -> D granted first, m_we=1; IF granted after one IDLE cycle.
REQ-038 d_req held high continuously with if_req=1, m_ack one cycle after each grant -> exactly 3 D grants then 1 IF grant, repeating.
REQ-039 d_req=1, m_ack never asserted -> d_ack=1, d_err=1, rdata=0 on 16th busy cycle; state IDLE next.
REQ-040 m_ack on cycle 16 (timeout cycle) -> d_ack=1, d_err=0, rdata=m_rdata.
REQ-041 rst pulsed 2 cycles into IF_BUSY, then m_ack pulsed -> m_req=0 after reset edge, no if_ack, starve_cnt=0.
